// File: rtl/data_type_pkg.sv
// Shared types and constants for the angle pipeline and its arbiter.
// Angles are Q.8 radians, so pi/2 is 402 and pi is 804.
package data_type;

    localparam int ANG_LAT = 7;
    localparam int ID_W    = 2;
    localparam int XY_W    = 19;

    typedef logic signed [15:0] gamma_t;
    typedef logic signed [15:0] ang_t;

    localparam ang_t ANG_HALF_PI = 16'sd402;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // atan(2^-i) in Q.8, rounded to nearest.
    function automatic ang_t atan_q8(input int i);
        case (i)
            0:       return 16'sd201;
            1:       return 16'sd119;
            2:       return 16'sd63;
            3:       return 16'sd32;
            4:       return 16'sd16;
            5:       return 16'sd8;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/angle.sv
// Pipelined vectoring CORDIC: one quadrant pre-rotation stage, then one
// stage per iteration. The result is valid ANG_LAT cycles after the inputs are sampled.
module angle
    import data_type::*;
(
    input  logic   clk,
    input  logic   rst,
    input  gamma_t real_in,
    input  gamma_t imag_in,
    output ang_t   ang_out
);

    typedef logic signed [XY_W-1:0] xy_t;

    xy_t  x_q [ANG_LAT];
    xy_t  y_q [ANG_LAT];
    ang_t z_q [ANG_LAT];
    xy_t  re_x;
    xy_t  im_x;

    // Extra headroom bits absorb the CORDIC gain and negation of the most negative input.
    assign re_x = xy_t'(real_in);
    assign im_x = xy_t'(imag_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ANG_LAT; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
            end
        end else begin
            // Fold the left half-plane onto the right half-plane so the iterations converge.
            if (re_x[XY_W-1] && !im_x[XY_W-1]) begin
                x_q[0] <= im_x;
                y_q[0] <= -re_x;
                z_q[0] <= ANG_HALF_PI;
            end else if (re_x[XY_W-1]) begin
                x_q[0] <= -im_x;
                y_q[0] <= re_x;
                z_q[0] <= -ANG_HALF_PI;
            end else begin
                x_q[0] <= re_x;
                y_q[0] <= im_x;
                z_q[0] <= '0;
            end
            for (int i = 1; i < ANG_LAT; i++) begin
                if (!y_q[i-1][XY_W-1]) begin
                    x_q[i] <= x_q[i-1] + (y_q[i-1] >>> (i-1));
                    y_q[i] <= y_q[i-1] - (x_q[i-1] >>> (i-1));
                    z_q[i] <= z_q[i-1] + atan_q8(i-1);
                end else begin
                    x_q[i] <= x_q[i-1] - (y_q[i-1] >>> (i-1));
                    y_q[i] <= y_q[i-1] + (x_q[i-1] >>> (i-1));
                    z_q[i] <= z_q[i-1] - atan_q8(i-1);
                end
            end
        end
    end

    assign ang_out = z_q[ANG_LAT-1];

endmodule

// File: rtl/angle_arbiter.sv
// Round-robin front end sharing one angle pipeline between NREQ requesters.
// A tag pipeline tracks who owns each in-flight result.
module angle_arbiter #(
    parameter int NREQ    = 2,
    parameter int ANG_LAT = data_type::ANG_LAT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  data_type::gamma_t [NREQ-1:0]        req_real,
    input  data_type::gamma_t [NREQ-1:0]        req_imag,
    output logic [NREQ-1:0]                     rsp_valid,
    output data_type::ang_t                     rsp_ang,
    output logic [$clog2(ANG_LAT+2)-1:0]        inflight
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gid;
    logic [PW:0]       cand;
    logic              gnt;
    logic              accept;
    logic              respond;
    data_type::gamma_t ang_re;
    data_type::gamma_t ang_im;
    data_type::ang_t   ang_out;
    data_type::tag_t   tag_q [ANG_LAT];
    data_type::tag_t   tag_out;

    always_comb begin
        gnt       = 1'b0;
        gid       = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (!gnt && req_valid[cand[PW-1:0]]) begin
                gnt = 1'b1;
                gid = cand[PW-1:0];
            end
        end
        if (gnt && !rst) req_ready[gid] = 1'b1;
    end

    assign accept = gnt && !rst;
    assign ang_re = accept ? req_real[gid] : '0;
    assign ang_im = accept ? req_imag[gid] : '0;

    angle u_angle (
        .clk     (clk),
        .rst     (rst),
        .real_in (ang_re),
        .imag_in (ang_im),
        .ang_out (ang_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < ANG_LAT; i++) tag_q[i] <= '0;
        end else begin
            if (accept) ptr <= (gid == PW'(NREQ-1)) ? '0 : gid + 1'b1;
            tag_q[0] <= '{valid: accept, id: data_type::ID_W'(gid)};
            for (int i = 1; i < ANG_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[ANG_LAT-1];
    assign respond = |rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_ang   <= '0;
            inflight  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                rsp_valid[i] <= tag_out.valid && (tag_out.id == data_type::ID_W'(i));
            if (tag_out.valid) rsp_ang <= ang_out;
            if (accept && !respond)      inflight <= inflight + 1'b1;
            else if (!accept && respond) inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: doc/angle_arbiter.md
ANGLE_ARBITER -- requirements
Module: angle_arbiter

Interface
REQ-001 Parameter: NREQ, 2, number of requesters sharing one angle pipeline (range 2..4).
REQ-002 Parameter: ANG_LAT, 7, fixed angle-pipeline latency in cycles (input sample edge to valid ang_out).
REQ-003 Port: clk  input  1  clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  NREQ  per-requester request strobe.
REQ-006 Port: req_ready  output  NREQ  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-007 Port: req_real  input  NREQ x gamma_t  per-requester real operand.
REQ-008 Port: req_imag  input  NREQ x gamma_t  per-requester imaginary operand.
REQ-009 Port: rsp_valid  output  NREQ  one-cycle result strobe, one-hot or zero.
REQ-010 Port: rsp_ang  output  ang_t  result angle, shared by all requesters, qualified by rsp_valid.
REQ-011 Port: inflight  output  $clog2(ANG_LAT+2)  number of accepted requests not yet returned.

Function
REQ-012 At most one bit of req_ready SHALL be high per cycle; req_ready is combinational from req_valid and the priority pointer.
REQ-013 Arbitration SHALL be round-robin: search starts at ptr; the first requester with req_valid high wins.
REQ-014 Pointer update: on a grant to index g, ptr SHALL become (g+1) mod NREQ next cycle; with no grant, ptr SHALL hold.
REQ-015 req_ready SHALL be zero for requesters whose req_valid is low (no grant without a request).
REQ-016 Granted operands SHALL drive the angle instance inputs in the grant cycle; with no grant, the inputs SHALL be driven to zero.
REQ-017 A tag pipeline of ANG_LAT entries, each {valid, id}, SHALL shift every cycle; entry 0 loads {grant, g}.
REQ-018 rsp_valid and rsp_ang SHALL be registered: a request accepted in cycle t returns in cycle t+ANG_LAT+1 (8 cycles with the default), with rsp_valid[id] high for exactly one cycle.
REQ-019 rsp_ang SHALL hold its last value when rsp_valid is zero.
REQ-020 Throughput SHALL be one accept per cycle; back-to-back grants from any mix of requesters SHALL return in accept order, with no gaps inserted.
REQ-021 There is no response backpressure; a requester SHALL consume rsp_valid in the cycle it is asserted.
REQ-022 inflight SHALL increment on accept and decrement on response; a simultaneous accept and response SHALL leave it unchanged; its maximum is ANG_LAT+1.
REQ-023 Arithmetic SHALL stay inside the angle instance; this block performs no width conversion on gamma_t or ang_t.

Reset
REQ-024 During rst: req_ready=0, rsp_valid=0, rsp_ang=0, inflight=0, ptr=0, all tag entries invalid.
REQ-025 rst asserted mid-operation SHALL drop all in-flight requests; no rsp_valid SHALL pulse for requests accepted before rst.
REQ-026 The angle instance SHALL share clk and rst.
REQ-027 The first grant is possible in the first cycle after rst deasserts.

Structure
REQ-028 gamma_t and ang_t SHALL come from package data_type; ANG_LAT SHALL be a localparam in data_type, and angle and angle_arbiter both use it.
REQ-029 The block SHALL contain exactly one instance of sub-module angle, plus the arbiter, tag pipeline, response register and counter.
REQ-030 The golden angle model SHALL be the bit-accurate C model of angle (quadrant pre-rotation plus 6 CORDIC iterations in Q.8).

Verification
REQ-031 Single request: req0 (256,0) at cycle 5 -> rsp_valid[0] at cycle 13; rsp_ang equals the golden value, within ±6 LSB of 0.
REQ-032 Quadrants: req1 (0,256), (-256,0+), (0,-256) -> results within ±6 LSB of 402, 804, -402, matching the golden model bit-exactly.
REQ-033 Both requesters held valid continuously for 20 cycles -> grants alternate 0,1,0,1 from ptr=0; 20 responses return in order to the matching ids; inflight is 8 in steady state.
REQ-034 Idle gap: req0 valid only every 3rd cycle, req1 never -> req0 is granted immediately each time; rsp_valid[1] is never high.
REQ-035 rst pulsed for 1 cycle with 5 requests in flight -> no rsp_valid for 9 cycles after the pulse, and inflight=0 on the cycle after rst.
REQ-036 Simultaneous accept and response each cycle in steady state -> inflight stays constant; a scoreboard sees no lost or duplicated responses.
